// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, constants and parity helper for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  // Falling edges that carry a frame: 8 data bits, parity, stop
  localparam int PS2_TX_BITS = 10;

  // 100 us inhibit and 20 ms watchdog at a 50 MHz system clock
  localparam int PS2_INHIBIT_CYCLES_DEFAULT = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 1000000;

  // PS/2 uses odd parity: the 9-bit {parity, data} word has an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-FF synchronizer with falling-edge detect for one PS/2 line
module ps2_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Lines idle high, so the chain resets to 1 and no edge is seen after reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional watchdog: PS2_TX_TIMEOUT_EN)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int               INH_W     = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0]       LAST_EDGE = 4'(PS2_TX_BITS - 1);

  ps2_tx_state_e    state_q;
  ps2_tx_state_e    state_d;
  logic [8:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic             data_oe_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic             clk_sync;
  logic             clk_fall;
  logic             dat_sync;
  logic             dat_fall_unused;
  logic             wd_expired;

  ps2_sync_edge u_clk_sync (
    .clock     (clock),
    .resetn    (resetn),
    .line_in   (ps2_clock_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clock     (clock),
    .resetn    (resetn),
    .line_in   (ps2_data_in),
    .line_sync (dat_sync),
    .line_fall (dat_fall_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;

  // Watchdog counts from START entry and is held clear while idle or inhibiting
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
    end else if (state_q == IDLE || state_q == INHIBIT) begin
      wd_cnt_q <= '0;
    end else if (!wd_expired) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  assign wd_expired = (state_q != IDLE) && (state_q != INHIBIT) && (wd_cnt_q == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame datapath: latch the byte, time the inhibit, shift bits out on device clock falls
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_oe_q <= 1'b0;
      inh_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          inh_cnt_q <= '0;
          bit_cnt_q <= '0;
          data_oe_q <= 1'b0;
          if (tx_start) begin
            shift_q <= {odd_parity(tx_data), tx_data};
          end
        end
        INHIBIT: begin
          inh_cnt_q <= inh_cnt_q + INH_W'(1);
        end
        START: begin
          data_oe_q <= 1'b1;
          bit_cnt_q <= '0;
        end
        SEND: begin
          if (clk_fall) begin
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[8:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // Next state and line/status outputs; done and error fire in the last busy-state cycle
  always_comb begin
    state_d      = state_q;
    ps2_clock_oe = 1'b0;
    ps2_data_oe  = 1'b0;
    tx_done      = 1'b0;
    tx_error     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) state_d = INHIBIT;
      end
      INHIBIT: begin
        ps2_clock_oe = 1'b1;
        if (inh_cnt_q == INH_LAST) state_d = START;
      end
      START: begin
        ps2_clock_oe = 1'b1;
        ps2_data_oe  = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        ps2_data_oe = data_oe_q;
        if (clk_fall && bit_cnt_q == LAST_EDGE) state_d = ACK;
      end
      ACK: begin
        if (clk_fall) begin
          if (dat_sync) begin
            tx_error = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (wd_expired) begin
      state_d      = IDLE;
      ps2_clock_oe = 1'b0;
      ps2_data_oe  = 1'b0;
      tx_done      = 1'b0;
      tx_error     = 1'b1;
    end
    tx_busy = (state_q != IDLE) && !tx_done && !tx_error;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH        = 5000;
  localparam int TB_TIMEOUT = 3000;
  localparam int H          = 6;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;
  int   err_cyc  = 0;
  int   start_cyc = 0;
  logic prev_busy = 1'b0;
  logic busy_before_done = 1'b0;
  logic busy_at_done = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  // Open-collector bus: a line is low if either side pulls it low
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame as seen on the data line before each device falling edge
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((d >> i) & 8'd1) != 8'd0;
    f[9]  = ($countones(d) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (tx_done) begin
      done_cnt++;
      busy_at_done     = tx_busy;
      busy_before_done = prev_busy;
    end
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_done && tx_error) both_cnt++;
    prev_busy = tx_busy;
  endtask

  task automatic transfer(input logic [7:0] d, input bit ack, input int exp_done,
                          input int exp_err, input int rst_edge, input int stop_edge,
                          input bit extra_start, input bit start_on_done);
    logic [10:0] seen;
    logic [10:0] expf;
    int          n;
    int          d0;
    int          e0;
    bit          aborted;
    expf    = model_frame(d);
    d0      = done_cnt;
    e0      = err_cnt;
    seen    = '0;
    aborted = 1'b0;
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("busy_at_inhibit", tx_busy, 1);
    n = 0;
    while (ps2_clock_oe && !ps2_data_oe && n < INH + 10) begin
      n++;
      tick();
    end
    check("inhibit_len", n, INH);
    check("start_bit_oe", {ps2_clock_oe, ps2_data_oe}, 2'b11);
    start_cyc = cyc;
    tick();
    check("send_hold_oe", {ps2_clock_oe, ps2_data_oe}, 2'b01);
    for (int e = 1; e <= 11; e++) begin
      repeat (H) tick();
      seen[e-1] = ps2_data_in;
      if (e == 11 && ack) begin
        dev_data = 1'b0;
        repeat (3) tick();
      end
      dev_clk = 1'b0;
      repeat (H) tick();
      if (e == rst_edge) begin
        resetn = 1'b0;
        #1;
        check("rst_oe", {ps2_clock_oe, ps2_data_oe}, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_error", tx_error, 0);
        tick();
        tick();
        resetn  = 1'b1;
        dev_clk = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (extra_start && e == 4) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      dev_clk = 1'b1;
      if (e == stop_edge) begin
        aborted = 1'b1;
        break;
      end
    end
    dev_data = 1'b1;
    if (aborted && rst_edge != 0) begin
      repeat (20) tick();
      check("rst_no_error", err_cnt - e0, 0);
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_idle_oe", {ps2_clock_oe, ps2_data_oe, tx_busy}, 0);
    end else if (aborted) begin
      n = 0;
      while (err_cnt == e0 && n < TB_TIMEOUT + 100) begin
        n++;
        tick();
      end
      check("timeout_error", err_cnt - e0, 1);
      check("timeout_released", {ps2_clock_oe, ps2_data_oe}, 0);
      check("timeout_window", (err_cyc - start_cyc >= TB_TIMEOUT) && (err_cyc - start_cyc <= TB_TIMEOUT + 2), 1);
      tick();
      check("timeout_done", done_cnt - d0, 0);
      check("timeout_idle", tx_busy, 0);
    end else begin
      check("frame", seen, expf);
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 80) begin
        n++;
        tick();
      end
      check("done_count", done_cnt - d0, exp_done);
      check("error_count", err_cnt - e0, exp_err);
      if (exp_done != 0) begin
        check("busy_before_done", busy_before_done, 1);
        check("busy_at_done", busy_at_done, 0);
      end
      if (start_on_done) begin
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("start_at_done_ignored", tx_busy, 0);
      end else begin
        tick();
        check("idle_after_end", {tx_busy, ps2_clock_oe, ps2_data_oe}, 0);
      end
      repeat (20) tick();
      check("single_done", done_cnt - d0, exp_done);
      check("no_queued_start", {tx_busy, ps2_clock_oe}, 0);
    end
    check("done_error_exclusive", both_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'hF4, ack: 1'b1, exp_done: 1, exp_err: 0};
    vecs[1] = '{data: 8'hED, ack: 1'b1, exp_done: 1, exp_err: 0};
    vecs[2] = '{data: 8'h00, ack: 1'b0, exp_done: 0, exp_err: 1};
    for (int i = 3; i < 7; i++) begin
      vecs[i].data     = 8'($urandom_range(0, 255));
      vecs[i].ack      = ($urandom_range(0, 3) != 0);
      vecs[i].exp_done = vecs[i].ack ? 1 : 0;
      vecs[i].exp_err  = vecs[i].ack ? 0 : 1;
    end

    repeat (3) tick();
    #1;
    check("reset_outputs", {ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 0);
    resetn = 1'b1;
    repeat (5) tick();
    check("idle_after_reset", {ps2_clock_oe, ps2_data_oe, tx_busy}, 0);

    for (int i = 0; i < 7; i++) begin
      transfer(vecs[i].data, vecs[i].ack, vecs[i].exp_done, vecs[i].exp_err, 0, 0, 1'b0, 1'b0);
    end

    transfer(8'hF4, 1'b1, 1, 0, 0, 0, 1'b1, 1'b1);
    transfer(8'hF4, 1'b1, 0, 0, 4, 0, 1'b0, 1'b0);
    transfer(8'h00, 1'b1, 1, 0, 0, 0, 1'b0, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    transfer(8'hF4, 1'b1, 0, 1, 0, 3, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, the clock-low inhibit time in clock cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the transfer watchdog limit in clock cycles (20 ms at 50 MHz).
REQ-003 SHALL have port clock, input, 1, the single system clock.
REQ-004 SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8, the command byte to send to the keyboard.
REQ-006 SHALL have port tx_start, input, 1, a one-cycle request to send tx_data.
REQ-007 SHALL have port ps2_clock_in, input, 1, the raw PS/2 clock line level (asynchronous).
REQ-008 SHALL have port ps2_data_in, input, 1, the raw PS/2 data line level (asynchronous).
REQ-009 SHALL have port ps2_clock_oe, output, 1, which drives the clock line low when 1 and releases it when 0.
REQ-010 SHALL have port ps2_data_oe, output, 1, which drives the data line low when 1 and releases it when 0.
REQ-011 SHALL have port tx_busy, output, 1, high from the accepted tx_start until the cycle before done or error.
REQ-012 SHALL have port tx_done, output, 1, a one-cycle pulse marking successful completion with device ACK.
REQ-013 SHALL have port tx_error, output, 1, a one-cycle pulse marking a missing ACK or a timeout.

Function
REQ-014 SHALL pass both line inputs through 2-FF synchronizers and detect the falling edge of the synchronized clock (fall = prev 1, now 0).
REQ-015 SHALL use states IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-016 SHALL in IDLE, on tx_start, latch tx_data, compute odd parity (parity = ~^tx_data), and enter INHIBIT on the next cycle with tx_busy = 1.
REQ-017 SHALL in INHIBIT assert ps2_clock_oe = 1 and ps2_data_oe = 0 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-018 SHALL in START assert ps2_clock_oe = 1 and ps2_data_oe = 1 (start bit) for one cycle, then enter SEND with ps2_clock_oe = 0 and ps2_data_oe held at 1.
REQ-019 SHALL in SEND, on each detected falling edge n = 1..10, drive ps2_data_oe = ~bit, where edges 1-8 send data LSB first, edge 9 sends parity, and edge 10 sends the stop bit (release).
REQ-020 SHALL in ACK sample the synchronized data line at the next falling edge: 0 means ACK and enters WAIT_IDLE; 1 pulses tx_error and enters IDLE.
REQ-021 SHALL in WAIT_IDLE wait until both synchronized lines are 1, then pulse tx_done and return to IDLE.
REQ-022 SHALL ignore tx_start when not in IDLE, with no latch and no queueing.
REQ-023 SHALL accept a tx_start that arrives in the same cycle as tx_done/tx_error only in the following cycle, since the block is not yet in IDLE.
REQ-024 SHALL release both line outputs (oe = 0) in every state except INHIBIT, START and SEND.
REQ-025 SHALL never assert tx_done and tx_error in the same cycle.

Reset
REQ-026 SHALL on resetn = 0 immediately (asynchronously) force state = IDLE, ps2_clock_oe = 0, ps2_data_oe = 0, tx_busy = 0, tx_done = 0, tx_error = 0, synchronizers = 1, and clear the counters.
REQ-027 SHALL abandon a mid-transfer reset silently, with no tx_error pulse, and leave the lines released.

Configuration
REQ-028 SHALL use macro PS2_TX_TIMEOUT_EN: when defined, a watchdog counting from the entry to START exceeding TIMEOUT_CYCLES releases both lines, pulses tx_error and returns to IDLE.
REQ-029 SHALL without PS2_TX_TIMEOUT_EN contain no watchdog counter, so SEND, ACK and WAIT_IDLE wait indefinitely.

Structure
REQ-030 SHALL place the state enum, the bit count constant (10 falling edges) and the default INHIBIT/TIMEOUT values in package ps2_pkg.
REQ-031 SHALL implement the synchronizer and falling-edge detector as sub-module ps2_sync_edge, instanced once per line.

Verification
REQ-032 SHALL test send 0xF4 with a device model acking: line sequence start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1, ACK low, then tx_done = 1 exactly once.
REQ-033 SHALL test send 0xED: parity 1 is driven on edge 9, ps2_clock_oe is high for exactly 5000 cycles, and the tx_busy pulse width spans INHIBIT through WAIT_IDLE.
REQ-034 SHALL test send 0x00 where the device holds data high at edge 11: tx_error = 1, tx_done = 0, and the block is IDLE on the next cycle.
REQ-035 SHALL test a second tx_start (0xFF) pulsed during SEND: it is ignored and only 0xF4 appears on the line.
REQ-036 SHALL test resetn = 0 after edge 4 of 0xF4: both oe = 0 in the same cycle, tx_busy = 0, no tx_error, and a new 0x00 send then completes.
REQ-037 SHALL test, with PS2_TX_TIMEOUT_EN defined, a device that stops clocking after edge 3: tx_error = 1 after TIMEOUT_CYCLES and both lines released.
